// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int unsigned DROP_W          = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order ring of fetch entries. head = oldest, fill = oldest unfilled, alloc = next free;
// the extra pointer bit separates full from empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH_DEF,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        alloc_i,
  input  logic [31:0] alloc_pc_i,
  input  logic        fill_i,
  input  logic [31:0] fill_data_i,
  input  logic        pop_i,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_instr_o,
  output logic        head_filled_o,
  output logic [AW:0] occupancy_o,
  output logic [AW:0] unfilled_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fetch_entry_t entries_q [DEPTH];
  logic [AW:0]  head_q, head_d;
  logic [AW:0]  alloc_q, alloc_d;
  logic [AW:0]  fill_q, fill_d;

  // Pointer advance; a flush rewinds everything to an empty ring.
  always_comb begin
    head_d  = head_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    if (flush_i) begin
      head_d  = '0;
      alloc_d = '0;
      fill_d  = '0;
    end else begin
      head_d  = pop_i   ? head_q  + PTR_ONE : head_q;
      alloc_d = alloc_i ? alloc_q + PTR_ONE : alloc_q;
      fill_d  = fill_i  ? fill_q  + PTR_ONE : fill_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q  <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
    end else begin
      head_q  <= head_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
    end
  end

  // Entry storage: allocation stamps the pc, a response fills the word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i].filled <= 1'b0;
      end
    end else begin
      if (alloc_i) begin
        entries_q[alloc_q[AW-1:0]] <= '{pc: alloc_pc_i, instr: 32'h0000_0000, filled: 1'b0};
      end
      if (fill_i) begin
        entries_q[fill_q[AW-1:0]].instr  <= fill_data_i;
        entries_q[fill_q[AW-1:0]].filled <= 1'b1;
      end
    end
  end

  assign occupancy_o   = alloc_q - head_q;
  assign unfilled_o    = alloc_q - fill_q;
  assign head_pc_o     = entries_q[head_q[AW-1:0]].pc;
  assign head_instr_o  = entries_q[head_q[AW-1:0]].instr;
  // A slot is only reused after allocation clears its filled bit, so this is exact when non-empty.
  assign head_filled_o = (occupancy_o != '0) && entries_q[head_q[AW-1:0]].filled;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC generation, imem request/response tracking, redirect flush.
// Optional FETCH_BYPASS_EN forwards a response to the datapath in its arrival cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = FETCH_DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned       AW       = $clog2(DEPTH);
  localparam logic [AW:0]       DEPTH_P  = (AW + 1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W - 1){1'b0}}, 1'b1};

  fetch_state_t      state_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [31:0]       fetch_pc_q, fetch_pc_d;

  logic              grant_s, fill_s, pop_s, head_valid_s;
  logic [31:0]       head_pc_s, head_instr_s;
  logic              head_filled_s;
  logic [AW:0]       occupancy_s, unfilled_s;
  logic [DROP_W-1:0] redir_sum_s, redir_cnt_s;

  assign imem_req_o  = rst_i && !redirect_i && (occupancy_s != DEPTH_P);
  assign imem_addr_o = fetch_pc_q;
  assign grant_s     = imem_req_o && imem_gnt_i;

  // Responses only fill while no stale requests are owed; excess responses are ignored.
  assign fill_s       = imem_rvalid_i && (state_q == RUN) && !redirect_i && (unfilled_s != '0);
  assign head_valid_s = head_filled_s && !redirect_i;

`ifdef FETCH_BYPASS_EN
  logic bypass_s;
  assign bypass_s      = fill_s && !head_filled_s;
  assign instr_valid_o = head_valid_s || bypass_s;
  assign instr_o       = bypass_s ? imem_rdata_i : (head_valid_s ? head_instr_s : 32'h0000_0000);
`else
  assign instr_valid_o = head_valid_s;
  assign instr_o       = head_valid_s ? head_instr_s : 32'h0000_0000;
`endif
  assign instr_pc_o    = instr_valid_o ? head_pc_s : 32'h0000_0000;
  assign pop_s         = instr_valid_o && instr_ready_i;

  // Everything still owed by memory at a redirect; a response landing now is already spent.
  assign redir_sum_s = drop_cnt_q + {{(DROP_W - AW - 1){1'b0}}, unfilled_s};
  assign redir_cnt_s = (imem_rvalid_i && (redir_sum_s != '0)) ? (redir_sum_s - DROP_ONE) : redir_sum_s;

  // Next fetch address.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
    end else if (grant_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // RUN/FLUSH control with the count of stale responses to discard.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      drop_cnt_q <= '0;
    end else if (redirect_i) begin
      drop_cnt_q <= redir_cnt_s;
      state_q    <= (redir_cnt_s != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN: begin
          state_q    <= RUN;
          drop_cnt_q <= drop_cnt_q;
        end
        FLUSH: begin
          if (imem_rvalid_i) begin
            drop_cnt_q <= drop_cnt_q - DROP_ONE;
            state_q    <= (drop_cnt_q == DROP_ONE) ? RUN : FLUSH;
          end else begin
            drop_cnt_q <= drop_cnt_q;
            state_q    <= FLUSH;
          end
        end
        default: begin
          state_q    <= RUN;
          drop_cnt_q <= '0;
        end
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_i),
    .alloc_i      (grant_s),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (fill_s),
    .fill_data_i  (imem_rdata_i),
    .pop_i        (pop_s),
    .head_pc_o    (head_pc_s),
    .head_instr_o (head_instr_s),
    .head_filled_o(head_filled_s),
    .occupancy_o  (occupancy_s),
    .unfilled_o   (unfilled_s)
  );

endmodule
